fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of four requesters bursts of writes into a shared 8-bit FIFO.
// Optional full-stall counter enabled by defining FIFO_WR_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [31:0] wdata,
    input  logic        fifo_full,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic        fifo_wr,
    output logic [7:0]  fifo_datain,
    output logic [7:0]  stall_cnt
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] XFER      = 1'b1;
    localparam logic [3:0] LAST_WORD = 4'(BURST_MAX - 1);

    logic [0:0] state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [1:0] pick;
    logic       pick_vld;
    logic [3:0] wcnt;
    logic       xfer;
    logic       owner_req;
    logic       burst_end;

    // Scan from ptr+1 upward; walking k downward lets the nearest requester overwrite farther ones.
    always_comb begin
        logic [1:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign xfer        = (state == XFER);
    assign owner_req   = req[owner];
    assign fifo_wr     = xfer & owner_req & ~fifo_full;
    assign ack         = fifo_wr ? (4'b0001 << owner) : 4'b0000;
    assign fifo_datain = xfer ? wdata[{owner, 3'b000} +: 8] : 8'h00;
    assign burst_end   = (fifo_wr & last[owner])
                       | (fifo_wr & (wcnt == LAST_WORD))
                       | ~owner_req;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= 2'd3;
            owner <= 2'd0;
            wcnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= XFER;
                        gnt   <= 4'b0001 << pick;
                        owner <= pick;
                        wcnt  <= 4'd0;
                    end
                end
                default: begin
                    if (burst_end) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        ptr   <= owner;
                    end else if (fifo_wr) begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [7:0] stall_q;

    // Counts cycles the owner wanted to write but the FIFO was full; saturates rather than wraps.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stall_q <= 8'h00;
        end else if (xfer & owner_req & fifo_full & (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'h01;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_fifo_wr_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] wdata;
    logic        fifo_full;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        fifo_wr;
    logic [7:0]  fifo_datain;
    logic [7:0]  stall_cnt;

    int passed = 0;
    int total  = 0;

    // Reference model: current owner (-1 = none), words written, rotation pointer, stall count.
    int m_owner;
    int m_wcnt;
    int m_ptr;
    int m_stall;

    fifo_wr_arbiter #(.BURST_MAX(BM)) dut (
        .clk         (clk),
        .res         (res),
        .req         (req),
        .last        (last),
        .wdata       (wdata),
        .fifo_full   (fifo_full),
        .gnt         (gnt),
        .ack         (ack),
        .fifo_wr     (fifo_wr),
        .fifo_datain (fifo_datain),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] onehot(input int i);
        if (i < 0) return 4'b0000;
        return 4'(1 << i);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_wcnt  = 0;
        m_ptr   = 3;
        m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic       ewr;
        logic [7:0] edat;
        ewr  = 1'b0;
        edat = 8'h00;
        if (m_owner >= 0) begin
            ewr  = req[m_owner] && !fifo_full;
            edat = wdata[8*m_owner +: 8];
        end
        chk({tag, ".gnt"}, {28'd0, gnt}, {28'd0, onehot(m_owner)});
        chk({tag, ".fifo_wr"}, {31'd0, fifo_wr}, {31'd0, ewr});
        chk({tag, ".ack"}, {28'd0, ack}, {28'd0, (ewr ? onehot(m_owner) : 4'b0000)});
        chk({tag, ".datain"}, {24'd0, fifo_datain}, {24'd0, edat});
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk({tag, ".stall"}, {24'd0, stall_cnt}, m_stall);
`else
        chk({tag, ".stall"}, {24'd0, stall_cnt}, 32'd0);
`endif
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic wr;
        if (!res) return;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_wcnt  = 0;
                    break;
                end
            end
        end else begin
            wr = req[m_owner] && !fifo_full;
            if (req[m_owner] && fifo_full && m_stall < 255) m_stall++;
            if ((wr && last[m_owner]) || (wr && m_wcnt == BM - 1) || !req[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (wr) begin
                m_wcnt++;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b0;
        model_reset();
        cycle("rst");
        cycle("rst");
        res = 1'b1;
    endtask

    initial begin
        res       = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        wdata     = 32'h0;
        fifo_full = 1'b0;
        model_reset();

        // Reset state, then single requester with last on 2nd word.
        do_reset();
        cycle("idle");
        wdata = 32'hA1B2C3D4;
        req   = 4'b0001;
        cycle("req0");
        chk("req0.gnt_latency", {28'd0, gnt}, 32'd1);
        cycle("req0.w1");
        last = 4'b0001;
        wdata = 32'h11223344;
        cycle("req0.w2");
        chk("req0.back_idle", {28'd0, gnt}, 32'd0);
        req  = 4'b0000;
        last = 4'b0000;
        cycle("req0.idle");

        // All four requesting: round robin with full bursts.
        req = 4'b1111;
        for (int i = 0; i < 26; i++) begin
            wdata = $urandom;
            last  = {$urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b0} & 4'b0000;
            cycle("rr");
        end
        req = 4'b0000;
        cycle("rr.end");

        // Owner 2 stalled by full FIFO for five cycles.
        do_reset();
        req = 4'b0100;
        cycle("stall.grant");
        chk("stall.gnt", {28'd0, gnt}, 32'h4);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) cycle("stall");
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("stall.count5", {24'd0, stall_cnt}, 32'd5);
`endif
        cycle("stall.resume");
        req = 4'b0000;
        cycle("stall.end");
        cycle("stall.idle");

        // Owner 1 drops request after one write; requester 2 wins next.
        req = 4'b0010;
        cycle("drop.grant");
        cycle("drop.w1");
        req = 4'b0100;
        cycle("drop.exit");
        cycle("drop.idle");
        chk("drop.next_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        cycle("drop.end");
        cycle("drop.idle2");

        // Reset mid-burst after two writes.
        req = 4'b0001;
        cycle("mid.grant");
        cycle("mid.w1");
        cycle("mid.w2");
        #2;
        res = 1'b0;
        model_reset();
        #1;
        check_outputs("mid.async");
        cycle("mid.held");
        req = 4'b0010;
        res = 1'b1;
        cycle("mid.regrant");
        chk("mid.gnt1", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        cycle("mid.end");
        cycle("mid.idle");

        // Long stall to exercise saturation.
        do_reset();
        req       = 4'b0001;
        fifo_full = 1'b1;
        for (int i = 0; i < 301; i++) cycle("sat");
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("sat.ff", {24'd0, stall_cnt}, 32'hFF);
`endif
        fifo_full = 1'b0;
        req       = 4'b0000;
        cycle("sat.end");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            req       = 4'($urandom_range(0, 15) | ($urandom_range(0, 3) == 0 ? 0 : 4'b0000));
            last      = 4'($urandom) & 4'($urandom);
            wdata     = $urandom;
            fifo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                res = 1'b0;
                model_reset();
                #1;
                check_outputs("rnd.async");
                res = 1'b1;
            end
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
